// File: rtl/swan_key_sched_seq_if.sv
// Subkey schedule handshake bundle: start/mode/key on the request side,
// valid/ready subkey stream plus status on the response side.
interface swan_key_sched_seq_if #(
  parameter int KEY_SIZE  = 256,
  parameter int SIDE_SIZE = 32,
  parameter int RW        = 6
);
  logic                 start;
  logic                 mode;
  logic [KEY_SIZE-1:0]  key_in;
  logic                 busy;
  logic                 sk_valid;
  logic                 sk_ready;
  logic [SIDE_SIZE-1:0] sk;
  logic [RW-1:0]        sk_round;
  logic                 sk_last;
  logic                 done;

  modport master (
    output start, mode, key_in, sk_ready,
    input  busy, sk_valid, sk, sk_round, sk_last, done
  );

  modport slave (
    input  start, mode, key_in, sk_ready,
    output busy, sk_valid, sk, sk_round, sk_last, done
  );
endinterface

// File: rtl/swan_key_sched_seq.sv
// Sequential SWAN round-key generator: one subkey per handshake, forward or
// reverse order; reverse order fast-forwards from the master key first.
module swan_key_sched_seq #(
  parameter int          BLOCK_SIZE = 64,
  parameter int          KEY_SIZE   = 256,
  parameter int          ROUNDS     = 32,
  parameter int          PD         = 24,
  parameter logic [31:0] DELTA0     = 32'h9e3779b9,
  localparam int         SIDE_SIZE  = BLOCK_SIZE / 2,
  localparam int         RW         = $clog2(ROUNDS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  swan_key_sched_seq_if.slave bus
);
  localparam logic [SIDE_SIZE-1:0] DELTA = SIDE_SIZE'(DELTA0);

  typedef enum logic [1:0] {IDLE, PRE, EMIT} state_t;

  state_t               state_q, state_d;
  logic [KEY_SIZE-1:0]  k_q;
  logic [SIDE_SIZE-1:0] d_q;
  logic [RW-1:0]        rnd_q;
  logic                 mode_q, done_q;
  logic                 sk_valid, sk_last, hs;

  function automatic logic [KEY_SIZE-1:0] rotr(input logic [KEY_SIZE-1:0] k);
    return (k >> PD) | (k << (KEY_SIZE - PD));
  endfunction

  function automatic logic [KEY_SIZE-1:0] rotl(input logic [KEY_SIZE-1:0] k);
    return (k << PD) | (k >> (KEY_SIZE - PD));
  endfunction

  // dn is the already-incremented delta D'
  function automatic logic [KEY_SIZE-1:0] f_key(input logic [KEY_SIZE-1:0] k,
                                                input logic [SIDE_SIZE-1:0] dn);
    logic [KEY_SIZE-1:0] r;
    r = rotr(k);
    r[SIDE_SIZE-1:0] = r[SIDE_SIZE-1:0] + dn;
    return r;
  endfunction

  function automatic logic [KEY_SIZE-1:0] b_key(input logic [KEY_SIZE-1:0] k,
                                                input logic [SIDE_SIZE-1:0] d);
    logic [KEY_SIZE-1:0] t;
    t = k;
    t[SIDE_SIZE-1:0] = t[SIDE_SIZE-1:0] - d;
    return rotl(t);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = bus.mode ? PRE : EMIT;
      PRE:  if (rnd_q == RW'(ROUNDS - 1)) state_d = EMIT;
      EMIT: if (hs && sk_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sk_valid = (state_q == EMIT);
    sk_last  = sk_valid && (mode_q ? (rnd_q == RW'(1)) : (rnd_q == RW'(ROUNDS)));
  end

  assign hs           = sk_valid & bus.sk_ready;
  assign bus.busy     = (state_q != IDLE);
  assign bus.sk_valid = sk_valid;
  assign bus.sk_last  = sk_last;
  assign bus.sk       = k_q[SIDE_SIZE-1:0];
  assign bus.sk_round = rnd_q;
  assign bus.done     = done_q;

  // The final handshake also steps, so a decrypt run leaves (K,D) back at (key_in,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q    <= '0;
      d_q    <= '0;
      rnd_q  <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          mode_q <= bus.mode;
          if (bus.mode) begin
            k_q   <= bus.key_in;
            d_q   <= '0;
            rnd_q <= '0;
          end else begin
            k_q   <= f_key(bus.key_in, DELTA);
            d_q   <= DELTA;
            rnd_q <= RW'(1);
          end
        end
        PRE: begin
          k_q   <= f_key(k_q, d_q + DELTA);
          d_q   <= d_q + DELTA;
          rnd_q <= (rnd_q == RW'(ROUNDS - 1)) ? RW'(ROUNDS) : rnd_q + RW'(1);
        end
        EMIT: if (hs) begin
          if (mode_q) begin
            k_q   <= b_key(k_q, d_q);
            d_q   <= d_q - DELTA;
            rnd_q <= rnd_q - RW'(1);
          end else begin
            k_q   <= f_key(k_q, d_q + DELTA);
            d_q   <= d_q + DELTA;
            rnd_q <= rnd_q + RW'(1);
          end
          if (sk_last) begin
            rnd_q  <= '0;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
